// File: rtl/issue_sb.sv
// issue_sb: in-order issue stage. A small instruction FIFO feeds a decoder whose head is
// held back by a per-register countdown scoreboard; empty or blocked cycles issue NOP bubbles.
module issue_sb #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in_ins,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [2:0]  out_opcode,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [11:0] out_imm,
    output logic        out_valid,
    output logic        stall,
    output logic [15:0] stall_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] LAT_V  = CW'(LAT);
    localparam logic [PW:0]   FULL_V = (PW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_MUL  = 3'b010,
        OP_ADDI = 3'b011
    } opcode_e;

    // Only bits [24:0] carry fields, so the FIFO stores just those.
    logic [24:0]   fifo_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;
    logic [CW-1:0] sb_q [32];
    logic [CW-1:0] sb_d [32];
    logic [15:0]   stallCnt_q, stallCnt_d;
    logic [2:0]    outOpcode_q, outOpcode_d;
    logic [4:0]    outRs1_q, outRs1_d, outRs2_q, outRs2_d, outRd_q, outRd_d;
    logic [11:0]   outImm_q, outImm_d;
    logic          outValid_q, outValid_d;

    logic [24:0] head;
    logic [2:0]  headOp;
    logic [4:0]  headRs1, headRs2, headRd;
    logic [11:0] headImm;
    logic        useRs1, useRs2, isReal, blocked, empty, push, pop;
    logic        unusedInsBits;

    assign unusedInsBits = ^in_ins[31:25];

    always_comb begin
        head    = fifo_q[rptr_q];
        headOp  = head[2:0];
        headRs1 = head[7:3];
        headRd  = head[12:8];
        headRs2 = head[17:13];
        headImm = head[24:13];
        useRs1  = 1'b0;
        useRs2  = 1'b0;
        isReal  = 1'b0;
        case (headOp)
            OP_ADD, OP_MUL: begin
                useRs1 = 1'b1;
                useRs2 = 1'b1;
                isReal = 1'b1;
            end
            OP_ADDI: begin
                useRs1 = 1'b1;
                isReal = 1'b1;
            end
            default: ;
        endcase
        blocked = (useRs1 && (headRs1 != 5'd0) && (sb_q[headRs1] != '0)) ||
                  (useRs2 && (headRs2 != 5'd0) && (sb_q[headRs2] != '0));
    end

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != FULL_V);
    assign stall    = !empty && blocked;
    assign pop      = start && !empty && !blocked;
    assign push     = start && in_valid && in_ready;

    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // A fresh issue reloads its destination after the global decrement, so the set wins.
        for (int r = 0; r < 32; r++) begin
            sb_d[r] = (sb_q[r] != '0) ? sb_q[r] - 1'b1 : sb_q[r];
        end
        if (pop && isReal && (headRd != 5'd0)) begin
            sb_d[headRd] = LAT_V;
        end

        stallCnt_d = (stall && (stallCnt_q != 16'hFFFF)) ? stallCnt_q + 16'd1 : stallCnt_q;

        outOpcode_d = 3'b000;
        outRs1_d    = 5'd0;
        outRs2_d    = 5'd0;
        outRd_d     = 5'd0;
        outImm_d    = 12'd0;
        outValid_d  = 1'b0;
        if (pop && isReal) begin
            outOpcode_d = headOp;
            outRs1_d    = headRs1;
            outRs2_d    = headRs2;
            outRd_d     = headRd;
            outImm_d    = headImm;
            outValid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= in_ins[24:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            sb_q        <= '{default: '0};
            stallCnt_q  <= 16'd0;
            outOpcode_q <= 3'b000;
            outRs1_q    <= 5'd0;
            outRs2_q    <= 5'd0;
            outRd_q     <= 5'd0;
            outImm_q    <= 12'd0;
            outValid_q  <= 1'b0;
        end else if (start) begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            sb_q        <= sb_d;
            stallCnt_q  <= stallCnt_d;
            outOpcode_q <= outOpcode_d;
            outRs1_q    <= outRs1_d;
            outRs2_q    <= outRs2_d;
            outRd_q     <= outRd_d;
            outImm_q    <= outImm_d;
            outValid_q  <= outValid_d;
        end
    end

    assign out_opcode = outOpcode_q;
    assign out_rs1    = outRs1_q;
    assign out_rs2    = outRs2_q;
    assign out_rd     = outRd_q;
    assign out_imm    = outImm_q;
    assign out_valid  = outValid_q;
    assign stall_cnt  = stallCnt_q;
endmodule
